// File: rtl/grom_io_pkg.sv
// Shared I/O port map, status bit positions and UART serializer states for GROM I/O blocks.
// Latency: none (constants, types and a pure function only).
// Backpressure: not applicable.
package grom_io_pkg;

    // Port addresses on the low byte of the CPU address bus
    localparam logic [7:0] PORT_UART_DATA   = 8'h00;
    localparam logic [7:0] PORT_UART_STATUS = 8'h01;

    // Bit positions inside the UART status byte
    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Packs the status flags into the byte the CPU reads; unused bits read as zero
    function automatic logic [7:0] uart_status(input logic ovf, input logic full, input logic empty);
        logic [7:0] s;
        s                 = 8'h00;
        s[STAT_OVF_BIT]   = ovf;
        s[STAT_FULL_BIT]  = full;
        s[STAT_EMPTY_BIT] = empty;
        return s;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Small synchronous FIFO with first-word-fall-through read data (depth must be a power of two).
// Latency: a push is visible at pop_dat on the cycle after the push edge.
// Backpressure: full/empty use the pre-edge count; push while full is accepted only with a same-cycle pop, else dropped and flagged on drop.
module io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;
    assign pop_dat = mem[rd_ptr];

    // Storage array; contents are don't-care while the count says empty, so no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// CPU I/O-mapped UART transmitter: 4-byte FIFO feeding an 8N1 serializer, plus a status port.
// Latency: tx falls one cycle after a write into an empty idle block; a frame lasts 10*CLK_DIV cycles.
// Backpressure: none towards the CPU; a write into a full FIFO is dropped and latches the sticky ovf flag.
module io_uart_tx
    import grom_io_pkg::*;
#(
    parameter int         CLK_DIV     = 16,
    parameter logic [7:0] PORT_DATA   = PORT_UART_DATA,
    parameter logic [7:0] PORT_STATUS = PORT_UART_STATUS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    input  logic       we,
    input  logic       ioreq,
    output logic [7:0] data_out,
    output logic       tx,
    output logic       busy
);

    localparam logic [7:0] BAUD_LAST = 8'(CLK_DIV - 1);

    logic       wr;
    logic       rd_stat;
    logic       fifo_pop;
    logic [7:0] fifo_dat;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_drop;
    logic       ovf;

    tx_state_t  state;
    logic [7:0] shift;
    logic [2:0] bit_cnt;
    logic [7:0] baud_cnt;
    logic       baud_end;

    assign wr       = ioreq & we & (addr == PORT_DATA);
    assign rd_stat  = ioreq & ~we & (addr == PORT_STATUS);
    assign fifo_pop = (state == TX_IDLE);
    assign baud_end = (baud_cnt == BAUD_LAST);
    assign busy     = ~fifo_empty | (state != TX_IDLE);

    io_fifo #(
        .WIDTH (8),
        .DEPTH (4)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (wr),
        .push_dat (data_in),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .drop     (fifo_drop)
    );

    // Sticky overflow: a dropped write sets it, a status read clears it, set wins
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (fifo_drop) begin
            ovf <= 1'b1;
        end else if (rd_stat) begin
            ovf <= 1'b0;
        end
    end

    // Status read mux; anything else, and any cycle in reset, reads as zero
    always_comb begin
        data_out = 8'h00;
        if (reset && rd_stat) begin
            data_out = uart_status(ovf, fifo_full, fifo_empty);
        end
    end

    // Serializer: start bit, 8 data bits LSB first, stop bit, each CLK_DIV cycles, tx registered
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= TX_IDLE;
            tx       <= 1'b1;
            shift    <= 8'h00;
            bit_cnt  <= 3'd0;
            baud_cnt <= 8'd0;
        end else begin
            case (state)
                TX_IDLE: begin
                    tx <= 1'b1;
                    if (!fifo_empty) begin
                        shift    <= fifo_dat;
                        state    <= TX_START;
                        tx       <= 1'b0;
                        bit_cnt  <= 3'd0;
                        baud_cnt <= 8'd0;
                    end
                end
                TX_START: begin
                    if (baud_end) begin
                        baud_cnt <= 8'd0;
                        state    <= TX_DATA;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 8'd1;
                    end
                end
                TX_DATA: begin
                    if (baud_end) begin
                        baud_cnt <= 8'd0;
                        if (bit_cnt == 3'd7) begin
                            state <= TX_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 8'd1;
                    end
                end
                TX_STOP: begin
                    tx <= 1'b1;
                    if (baud_end) begin
                        baud_cnt <= 8'd0;
                        state    <= TX_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= TX_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_uart_tx.sv
// Self-checking bench for io_uart_tx: queue-based frame model compared every cycle, plus literal checks.
// Latency: inputs change 1 ns after each rising edge, outputs compared on the falling edge.
// Backpressure: exercises FIFO overflow, status-read clearing, mid-frame reset and random traffic.
module tb_io_uart_tx;
    import grom_io_pkg::*;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic       we = 1'b0;
    logic       ioreq = 1'b0;
    logic [7:0] data_out;
    logic       tx;
    logic       busy;

    io_uart_tx #(
        .CLK_DIV     (DIV),
        .PORT_DATA   (PORT_UART_DATA),
        .PORT_STATUS (PORT_UART_STATUS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .data_in  (data_in),
        .we       (we),
        .ioreq    (ioreq),
        .data_out (data_out),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Frame = 10 slots of DIV cycles: slot 0 start (0), slots 1..8 data LSB first, slot 9 stop (1)
    logic [7:0] q[$];
    bit         m_ovf = 1'b0;
    bit         m_run = 1'b0;
    bit         m_valid = 1'b0;
    int         m_t = 0;
    logic [7:0] m_cur = 8'h00;

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    always @(posedge clk) begin
        bit wr_m, rd_m, full_m, pop_m;
        if (!reset) begin
            q.delete();
            m_ovf   = 1'b0;
            m_run   = 1'b0;
            m_t     = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            wr_m   = ioreq && we && (addr == PORT_UART_DATA);
            rd_m   = ioreq && !we && (addr == PORT_UART_STATUS);
            full_m = (q.size() == 4);
            pop_m  = !m_run && (q.size() != 0);
            if (m_run) begin
                m_t++;
                if (m_t == 10 * DIV) m_run = 1'b0;
            end
            if (pop_m) begin
                m_cur = q.pop_front();
                m_run = 1'b1;
                m_t   = 0;
            end
            if (wr_m && (!full_m || pop_m)) q.push_back(data_in);
            if (wr_m && full_m && !pop_m) m_ovf = 1'b1;
            else if (rd_m) m_ovf = 1'b0;
        end
    end

    // Compare process: every cycle once the first reset edge has been seen
    always @(negedge clk) begin
        logic [7:0] exp_do;
        if (m_valid) begin
            chk("tx", {7'b0, tx}, {7'b0, (m_run ? frame_bit(m_cur, m_t / DIV) : 1'b1)});
            chk("busy", {7'b0, busy}, {7'b0, (m_run || q.size() != 0)});
            exp_do = 8'h00;
            if (reset && ioreq && !we && addr == PORT_UART_STATUS)
                exp_do = {5'b0, m_ovf, q.size() == 4, q.size() == 0};
            chk("data_out", data_out, exp_do);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit r, input bit io, input bit w, input logic [7:0] a, input logic [7:0] d);
        reset   = r;
        ioreq   = io;
        we      = w;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
        reset   = 1'b1;
        ioreq   = 1'b0;
        we      = 1'b0;
        addr    = 8'h00;
        data_in = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic wr_byte(input logic [7:0] d);
        drive(1'b1, 1'b1, 1'b1, PORT_UART_DATA, d);
    endtask

    task automatic rd_stat_chk(input string name, input logic [7:0] exp);
        reset = 1'b1;
        ioreq = 1'b1;
        we    = 1'b0;
        addr  = PORT_UART_STATUS;
        #1;
        chk(name, data_out, exp);
        @(posedge clk);
        #1;
        ioreq = 1'b0;
        addr  = 8'h00;
    endtask

    initial begin
        logic [9:0] a5_seq;
        int         lows;
        int         wr_pct;
        int         r;
        bit         rr;

        // Reset two cycles; status read attempted during reset must return zero
        @(posedge clk);
        #1;
        ioreq = 1'b1;
        we    = 1'b0;
        addr  = PORT_UART_STATUS;
        #1;
        chk("dout_in_reset", data_out, 8'h00);
        @(posedge clk);
        #1;
        ioreq = 1'b0;
        addr  = 8'h00;
        reset = 1'b1;
        chk("tx_after_reset", {7'b0, tx}, 8'h01);
        chk("busy_after_reset", {7'b0, busy}, 8'h00);
        rd_stat_chk("status_after_reset", 8'h01);

        // Single byte 0xA5: start, 1,0,1,0,0,1,0,1, stop, each DIV cycles
        a5_seq = 10'b1101001010;
        wr_byte(8'hA5);
        chk("tx_on_write_edge", {7'b0, tx}, 8'h01);
        chk("busy_on_write_edge", {7'b0, busy}, 8'h01);
        @(posedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("a5_slot%0d", k), {7'b0, tx}, {7'b0, a5_seq[k]});
            repeat (DIV) @(posedge clk);
            #1;
        end
        chk("a5_busy_done", {7'b0, busy}, 8'h00);
        chk("a5_tx_idle", {7'b0, tx}, 8'h01);

        // Memory write must not touch the FIFO
        drive(1'b1, 1'b0, 1'b1, 8'h00, 8'h5A);
        idle(3);
        chk("memwr_tx", {7'b0, tx}, 8'h01);
        rd_stat_chk("memwr_status", 8'h01);

        // Fill: first byte popped, four queued -> full; then overflow and clear
        for (int i = 1; i <= 5; i++) wr_byte(8'(i));
        rd_stat_chk("full_status", 8'h02);
        wr_byte(8'h06);
        rd_stat_chk("ovf_status", 8'h06);
        rd_stat_chk("ovf_cleared", 8'h02);
        idle(44);
        rd_stat_chk("midstream_status", 8'h00);
        idle(250);
        rd_stat_chk("drained_status", 8'h01);

        // Reset in the data phase of an 0xFF frame drops the frame and the queue
        wr_byte(8'hFF);
        wr_byte(8'h11);
        wr_byte(8'h22);
        idle(10);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("abort_tx", {7'b0, tx}, 8'h01);
        chk("abort_busy", {7'b0, busy}, 8'h00);
        lows = 0;
        for (int i = 0; i < 120; i++) begin
            idle(1);
            if (tx !== 1'b1) lows++;
        end
        chk("abort_no_tx", 8'(lows), 8'h00);
        rd_stat_chk("abort_status", 8'h01);

        // Random traffic, alternating heavy and light write load, rare resets
        for (int i = 0; i < 3000; i++) begin
            wr_pct = ((i / 500) % 2 == 0) ? 14 : 2;
            r      = int'($urandom_range(0, 99));
            rr     = ($urandom_range(0, 299) != 0);
            if (r < wr_pct)
                drive(rr, 1'b1, 1'b1, PORT_UART_DATA, 8'($urandom));
            else if (r < wr_pct + 12)
                drive(rr, 1'b1, 1'b0, PORT_UART_STATUS, 8'($urandom));
            else if (r < wr_pct + 20)
                drive(rr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            else if (r < wr_pct + 25)
                drive(rr, 1'b0, 1'b1, PORT_UART_DATA, 8'($urandom));
            else
                drive(rr, 1'b0, 1'b0, 8'h00, 8'h00);
        end
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/io_uart_tx.md
IO_UART_TX -- requirements
Module: io_uart_tx

Interface
REQ-001 Parameter CLK_DIV, default 16, clock cycles per serial bit (legal range 2..255).
REQ-002 Parameter PORT_DATA, default 8'h00, I/O port address of the transmit data register.
REQ-003 Parameter PORT_STATUS, default 8'h01, I/O port address of the status register.
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 addr  input  8  low byte of CPU address bus (CPU addr[7:0]).
REQ-007 data_in  input  8  write data from CPU data_out.
REQ-008 we  input  1  CPU write strobe.
REQ-009 ioreq  input  1  CPU I/O request; qualifies every access to this block.
REQ-010 data_out  output  8  read data to CPU, muxed with memory data by ioreq.
REQ-011 tx  output  1  serial line, idle high.
REQ-012 busy  output  1  high while FIFO non-empty or serializer not IDLE.

Function
REQ-013 Write strobe wr = ioreq & we & (addr == PORT_DATA); rd_stat = ioreq & ~we & (addr == PORT_STATUS).
REQ-014 On wr, data_in SHALL be pushed into a 4-entry FIFO at the clock edge.
REQ-015 Full/empty SHALL be evaluated on pre-edge count; push while full with a same-cycle pop SHALL be accepted.
REQ-016 Push while full without a same-cycle pop SHALL be dropped and SHALL set sticky bit ovf.
REQ-017 data_out SHALL be combinational: on rd_stat, {5'b0, ovf, full, empty}; otherwise 8'h00.
REQ-018 ovf SHALL clear on the edge ending a rd_stat cycle, unless a dropped push sets it in that same cycle (set wins).
REQ-019 Writes to PORT_STATUS and reads of PORT_DATA SHALL have no effect and return 8'h00.
REQ-020 Serializer states: IDLE, START, DATA, STOP.
REQ-021 IDLE: tx=1; if FIFO non-empty, pop head into shift register, go START, clear bit counter and baud counter.
REQ-022 START: tx=0 for CLK_DIV cycles, then DATA.
REQ-023 DATA: tx = shift[0], LSB first, each bit CLK_DIV cycles; after 8th bit go STOP.
REQ-024 STOP: tx=1 for CLK_DIV cycles, then IDLE.
REQ-025 One frame SHALL occupy exactly 10*CLK_DIV cycles from leaving IDLE to re-entering IDLE; back-to-back bytes add one IDLE cycle between frames.
REQ-026 Baud counter SHALL count 0..CLK_DIV-1 and wrap; FIFO pointers SHALL be 2-bit and wrap modulo 4, with 3-bit count.
REQ-027 A push arriving while the FIFO is empty and the serializer is in IDLE SHALL start transmission on the following edge (tx falls 1 cycle after write edge).

Reset
REQ-028 While reset==0 at an edge: state=IDLE, tx=1, FIFO empty, ovf=0, counters 0, busy=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame and discard FIFO contents; tx SHALL be 1 after that edge.
REQ-030 data_out SHALL be 8'h00 during reset regardless of ioreq.

Structure
REQ-031 Port addresses and status bit positions SHALL live in a shared package grom_io_pkg for reuse by other I/O blocks and the testbench.
REQ-032 FIFO SHALL be a sub-module io_fifo (parameterised width 8, depth 4) with push, pop, full, empty.
REQ-033 Top-level integration: CPU data_in = ioreq ? io_uart_tx.data_out : memory data_out; memory we stays we & ~ioreq.

Verification
REQ-034 Reset low 2 cycles then high -> tx=1, busy=0, status read = 8'h01.
REQ-035 Write 8'hA5 to port 0x00, CLK_DIV=4 -> tx sequence 0,1,0,1,0,0,1,0,1,1 each 4 cycles; busy low after 40 cycles.
REQ-036 Five writes 8'h01..8'h05 in consecutive cycles -> 8'h05 accepted (first byte popped), status=8'h00 mid-stream; sixth write while full -> status 8'h06, next status read 8'h02.
REQ-037 Read status with ovf set -> returns bit2=1; following read returns bit2=0.
REQ-038 Reset asserted in DATA state of 8'hFF frame -> tx=1 next cycle, busy=0, previously queued bytes never transmitted.
REQ-039 Memory write (ioreq=0, we=1, addr=8'h00) -> FIFO unchanged, tx stays 1.
